// File: rtl/refill_memory_responder_pkg.sv
// Shared definitions for the cache refill responder: FSM encodings, request
// operations and word addressing constants.
package refill_memory_responder_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RESPOND = 2'd2
   } state_t;

   // Bit 1 = write, bit 0 = read; both set means write with read-back of the written word.
   typedef enum logic [1:0] {
      OP_NONE       = 2'd0,
      OP_READ       = 2'd1,
      OP_WRITE      = 2'd2,
      OP_WRITE_READ = 2'd3
   } req_op_t;

   localparam int WORD_BYTES = 4;
   localparam int ADDR_LSB   = $clog2(WORD_BYTES);

   function automatic req_op_t decodeOp(input logic readEnable, input logic writeEnable);
      return req_op_t'({writeEnable, readEnable});
   endfunction

endpackage

// File: rtl/refill_memory_responder_if.sv
// Cache-side miss/write-back port between a CacheL1 instance and the refill responder.
interface refill_memory_responder_if;

   // Handshake: the cache raises cacheReadEnable and/or cacheWriteEnable with a stable
   // address/data and holds them until it sees cacheReady; cacheReady is a one-cycle
   // completion pulse and cacheReadData is valid while it is high and held afterwards.
   logic [31:0] cacheAddress;
   logic [31:0] cacheWriteData;
   logic        cacheReadEnable;
   logic        cacheWriteEnable;
   logic [31:0] cacheReadData;
   logic        cacheReady;

   modport master (
      output cacheAddress, cacheWriteData, cacheReadEnable, cacheWriteEnable,
      input  cacheReadData, cacheReady
   );

   modport slave (
      input  cacheAddress, cacheWriteData, cacheReadEnable, cacheWriteEnable,
      output cacheReadData, cacheReady
   );

endinterface

// File: rtl/refill_memory_responder_word_ram.sv
// Single-port-per-direction synchronous 32-bit word RAM with a registered read port.
module refill_memory_responder_word_ram #(
   parameter  int DEPTH_WORDS = 1024,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             writeEnable,
   input  logic             readEnable,
   input  logic [IDX_W-1:0] index,
   input  logic [31:0]      writeData,
   output logic [31:0]      readData
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (writeEnable) mem[index] <= writeData;
   end

   // Read-back of a simultaneous write returns the new word, not the stale one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           readData <= '0;
      else if (readEnable) readData <= writeEnable ? writeData : mem[index];
   end

endmodule

// File: rtl/refill_memory_responder.sv
// Memory-side responder for the CacheL1 miss/write-back port: accepts one word
// request, services it from word RAM after LATENCY edges, then pulses cacheReady.
module refill_memory_responder
   import refill_memory_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   refill_memory_responder_if.slave  cache,
   output logic                      busy,
   output state_t                    debugState
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_t           stateQ, stateD;
   logic [3:0]       counterQ, counterD;
   logic [IDX_W-1:0] indexQ, indexD;
   logic [31:0]      dataQ, dataD;
   req_op_t          opQ, opD;
   logic             commit;
   logic             ramWrite;
   logic             ramRead;
   logic             unusedAddrBits;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ   <= IDLE;
         counterQ <= '0;
         indexQ   <= '0;
         dataQ    <= '0;
         opQ      <= OP_NONE;
      end else begin
         stateQ   <= stateD;
         counterQ <= counterD;
         indexQ   <= indexD;
         dataQ    <= dataD;
         opQ      <= opD;
      end
   end

   // Enables are only looked at in IDLE; the cache still holds them through RESPOND.
   always_comb begin
      stateD   = stateQ;
      counterD = counterQ;
      indexD   = indexQ;
      dataD    = dataQ;
      opD      = opQ;
      commit   = 1'b0;
      case (stateQ)
         IDLE: begin
            if (cache.cacheReadEnable || cache.cacheWriteEnable) begin
               stateD   = BUSY;
               counterD = 4'(LATENCY - 1);
               indexD   = cache.cacheAddress[ADDR_LSB +: IDX_W];
               dataD    = cache.cacheWriteData;
               opD      = decodeOp(cache.cacheReadEnable, cache.cacheWriteEnable);
            end
         end
         BUSY: begin
            if (counterQ != 4'd0) begin
               counterD = counterQ - 4'd1;
            end else begin
               commit = 1'b1;
               stateD = RESPOND;
            end
         end
         RESPOND: stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   assign ramWrite = commit && (opQ == OP_WRITE || opQ == OP_WRITE_READ);
   assign ramRead  = commit && (opQ == OP_READ  || opQ == OP_WRITE_READ);

   refill_memory_responder_word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) wordRam (
      .clk         (clk),
      .reset       (reset),
      .writeEnable (ramWrite),
      .readEnable  (ramRead),
      .index       (indexQ),
      .writeData   (dataQ),
      .readData    (cache.cacheReadData)
   );

   // Byte-offset bits and bits above the index alias onto the same word.
   assign unusedAddrBits = ^{cache.cacheAddress[31:ADDR_LSB+IDX_W],
                             cache.cacheAddress[ADDR_LSB-1:0]};

   assign cache.cacheReady = (stateQ == RESPOND);
   assign busy             = (stateQ != IDLE);
   assign debugState       = stateQ;

endmodule

// File: tb/tb_refill_memory_responder.sv
// Scoreboard bench for refill_memory_responder: directed requests push expected
// read data and completion edge; a negedge monitor pops and compares on cacheReady.
module tb_refill_memory_responder;
   import refill_memory_responder_pkg::*;

   localparam int LAT   = 3;
   localparam int DEPTH = 1024;
   localparam int W     = 32;

   logic   clk = 1'b0;
   logic   reset;
   logic   busy;
   state_t debugState;

   refill_memory_responder_if bus();

   refill_memory_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cache      (bus),
      .busy       (busy),
      .debugState (debugState)
   );

   // ---------------- clock / edge counter ----------------
   always #5 clk = ~clk;

   int edgeCount = 0;
   always @(posedge clk) edgeCount <= edgeCount + 1;

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];
   int           expEdge_q[$];
   logic [W-1:0] memModel [int];
   logic [W-1:0] lastRead = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset !== 1'b1 && bus.cacheReady === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_ready", W'(bus.cacheReady), W'(0));
         end else begin
            check("read_data", bus.cacheReadData, exp_q.pop_front());
            check("ready_edge", W'(edgeCount), W'(expEdge_q.pop_front()));
         end
      end
   end

   // ---------------- driver ----------------
   task automatic doReq(input string name, input logic wr, input logic rd,
                        input logic [31:0] addr, input logic [31:0] data, input bit hold);
      int acceptEdge;
      int idx;
      bit seen;
      @(negedge clk);
      bus.cacheAddress     = addr;
      bus.cacheWriteData   = data;
      bus.cacheWriteEnable = wr;
      bus.cacheReadEnable  = rd;
      acceptEdge = edgeCount + 1;
      idx = int'((addr >> 2) % DEPTH);
      if (wr) memModel[idx] = data;
      if (wr && rd)  lastRead = data;
      else if (rd)   lastRead = memModel.exists(idx) ? memModel[idx] : 'x;
      exp_q.push_back(lastRead);
      expEdge_q.push_back(acceptEdge + LAT);
      for (int r = 0; r < (hold ? 2 : 1); r++) begin
         seen = 1'b0;
         for (int i = 0; i < 4 * LAT + 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.cacheReady === 1'b1) begin
               seen = 1'b1;
            end else if (!hold && i == 0) begin
               // Latched copy must be used: disturb the bus right after accept.
               bus.cacheAddress   = 32'h0000_0FFC;
               bus.cacheWriteData = 32'hBAD0_BAD0;
            end
         end
         if (!seen) check({name, "_timeout"}, W'(bus.cacheReady), W'(1));
         if (hold && r == 0 && seen) begin
            exp_q.push_back(lastRead);
            expEdge_q.push_back(edgeCount + 2 + LAT);
         end
      end
      bus.cacheReadEnable  = 1'b0;
      bus.cacheWriteEnable = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset                = 1'b1;
      bus.cacheAddress     = '0;
      bus.cacheWriteData   = '0;
      bus.cacheReadEnable  = 1'b0;
      bus.cacheWriteEnable = 1'b0;
      #1;
      check("reset_ready", W'(bus.cacheReady), W'(0));
      check("reset_busy", W'(busy), W'(0));
      check("reset_read_data", bus.cacheReadData, W'(0));
      check("reset_state", W'(debugState), W'(IDLE));
      repeat (2) @(negedge clk);
      reset = 1'b0;

      doReq("wr40",      1'b1, 1'b0, 32'h40,   32'hDEADBEEF, 1'b0);
      doReq("rd40",      1'b0, 1'b1, 32'h40,   32'h0,        1'b0);
      doReq("rd40_hold", 1'b0, 1'b1, 32'h40,   32'h0,        1'b1);
      doReq("both80",    1'b1, 1'b1, 32'h80,   32'h12345678, 1'b0);
      doReq("rd80",      1'b0, 1'b1, 32'h80,   32'h0,        1'b0);
      doReq("wr0",       1'b1, 1'b0, 32'h0,    32'hA5A5A5A5, 1'b0);
      doReq("rd1000",    1'b0, 1'b1, 32'h1000, 32'h0,        1'b0);
      doReq("rd3",       1'b0, 1'b1, 32'h3,    32'h0,        1'b0);
      doReq("wr10_old",  1'b1, 1'b0, 32'h10,   32'h11111111, 1'b0);

      // Write that is aborted by reset while BUSY.
      @(negedge clk);
      bus.cacheAddress     = 32'h10;
      bus.cacheWriteData   = 32'h22222222;
      bus.cacheWriteEnable = 1'b1;
      @(negedge clk);
      check("abort_busy_before", W'(busy), W'(1));
      check("abort_state_before", W'(debugState), W'(BUSY));
      bus.cacheWriteEnable = 1'b0;
      reset = 1'b1;
      #1;
      check("abort_ready", W'(bus.cacheReady), W'(0));
      check("abort_busy", W'(busy), W'(0));
      check("abort_read_data", bus.cacheReadData, W'(0));
      check("abort_state", W'(debugState), W'(IDLE));
      lastRead = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (2 * LAT + 2) @(negedge clk);
      check("abort_idle_after", W'(debugState), W'(IDLE));

      doReq("rd10_after_abort", 1'b0, 1'b1, 32'h10, 32'h0, 1'b0);

      repeat (LAT + 3) @(negedge clk);
      check("queue_empty", W'(exp_q.size()), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
